// File: rtl/swo_itm_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// swo_itm_tx - frames ITM stimulus-port packets and serialises them on SWO
// Rev 1.0
// ---------------------------------------------------------------------------
module swo_itm_tx #(
  parameter int pDIV_WIDTH   = 16,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic                    I_enable,
  input  logic                    I_manchester,
  input  logic [pDIV_WIDTH-1:0]   I_baud_div,
  input  logic                    I_valid,
  output logic                    O_ready,
  input  logic [4:0]              I_port,
  input  logic [1:0]              I_size,
  input  logic [31:0]             I_payload,
  output logic                    O_swo,
  output logic                    O_busy,
  output logic [pCOUNT_WIDTH-1:0] O_pkt_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [pDIV_WIDTH-1:0]   c_DIV_ONE = {{(pDIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pCOUNT_WIDTH-1:0] c_CNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]              r_state;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_swo;
  logic                    r_man;
  logic                    r_half;
  logic [pDIV_WIDTH-1:0]   r_div;
  logic [pDIV_WIDTH-1:0]   r_div_cnt;
  logic [39:0]             r_pkt;
  logic [2:0]              r_bit_cnt;
  logic [2:0]              r_bytes_left;
  logic [pCOUNT_WIDTH-1:0] r_count;

  logic                    w_xfer;
  logic                    w_tick;
  logic                    w_bit_end;
  logic [2:0]              w_extra;

  assign w_xfer    = I_valid && r_ready;
  assign w_tick    = (r_div_cnt == '0);
  // NRZ bits have a single phase; Manchester bits end after the second half
  assign w_bit_end = w_tick && (!r_man || r_half);

  always_comb begin
    w_extra = 3'd0;
    case (I_size)
      2'b00:   w_extra = 3'd0;
      2'b01:   w_extra = 3'd1;
      2'b10:   w_extra = 3'd2;
      default: w_extra = 3'd4;
    endcase
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_swo        <= 1'b1;
      r_man        <= 1'b0;
      r_half       <= 1'b0;
      r_div        <= '0;
      r_div_cnt    <= '0;
      r_pkt        <= '0;
      r_bit_cnt    <= '0;
      r_bytes_left <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state      <= S_START;
            r_ready      <= 1'b0;
            r_busy       <= 1'b1;
            r_man        <= I_manchester;
            r_div        <= I_baud_div;
            r_div_cnt    <= I_baud_div;
            r_pkt        <= {I_payload, I_port, 1'b0, I_size};
            r_bytes_left <= w_extra;
            r_bit_cnt    <= '0;
            r_half       <= 1'b0;
            // start bit: NRZ low, Manchester '1' begins high
            r_swo        <= I_manchester;
          end else begin
            r_ready <= I_enable;
            r_swo   <= ~I_manchester;
          end
        end

        S_START, S_DATA, S_STOP: begin
          if (!w_tick) begin
            r_div_cnt <= r_div_cnt - c_DIV_ONE;
          end else begin
            r_div_cnt <= r_div;
            if (!w_bit_end) begin
              r_half <= 1'b1;
              r_swo  <= (r_state == S_DATA) ? ~r_pkt[0] : 1'b0;
            end else begin
              r_half <= 1'b0;
              case (r_state)
                S_START: begin
                  r_state <= S_DATA;
                  r_swo   <= r_pkt[0];
                end
                S_DATA: begin
                  // whole packet shifts so the next byte lands in [7:0]
                  r_pkt     <= r_pkt >> 1;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                    r_state <= S_STOP;
                    r_swo   <= ~r_man;
                  end else begin
                    r_swo <= r_pkt[1];
                  end
                end
                default: begin
                  if (r_bytes_left == 3'd0) begin
                    // count and busy settle on entry to DONE so busy spans only the line time
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_count <= r_count + c_CNT_ONE;
                    r_swo   <= ~r_man;
                  end else begin
                    r_bytes_left <= r_bytes_left - 3'd1;
                    r_state      <= S_START;
                    r_swo        <= r_man;
                  end
                end
              endcase
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= I_enable;
          r_swo   <= ~I_manchester;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign O_ready     = r_ready;
  assign O_busy      = r_busy;
  assign O_swo       = r_swo;
  assign O_pkt_count = r_count;

endmodule
`default_nettype wire

// File: doc/swo_itm_tx.md
Name: swo_itm_tx

Overview:
- On-board SWO trace transmitter. Frames host-supplied words as ITM stimulus-port packets and serialises them onto a single SWO pin.
- Encoding is either UART/NRZ or Manchester.
- Loopback source for the trace capture path: O_swo is strapped to a userio pin to self-test the SWO receiver and matcher without a target.
- Lives in the fe_clk domain beside the trace capture logic. Configured from registers.

Parameters:
pDIV_WIDTH, 16, width of the bit-period divider input.
pCOUNT_WIDTH, 16, width of the packet-sent counter.

Ports:
fe_clk  input  1  clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
I_enable  input  1  transmitter enable.
I_manchester  input  1  0 = NRZ/UART, 1 = Manchester.
I_baud_div  input  pDIV_WIDTH  NRZ: bit period = I_baud_div+1 cycles. Manchester: half-bit period = I_baud_div+1 cycles.
I_valid  input  1  packet request.
O_ready  output  1  block can accept a packet.
I_port  input  5  ITM stimulus port number.
I_size  input  2  payload bytes: 00 = 0, 01 = 1, 10 = 2, 11 = 4.
I_payload  input  32  payload, sent LSB byte first.
O_swo  output  1  serial trace output.
O_busy  output  1  packet in flight.
O_pkt_count  output  pCOUNT_WIDTH  packets completed; wraps.

Behaviour:
- Reset values:
  - O_swo = 1, O_ready = 0, O_busy = 0, O_pkt_count = 0.
  - State IDLE. All shift and bit counters cleared.
  - Reset mid-packet aborts immediately; no partial-packet count.
- Handshake:
  - O_ready = (state == IDLE) && I_enable; registered.
  - A transfer occurs on a cycle with I_valid && O_ready.
  - I_port, I_size, I_payload, I_manchester and I_baud_div are captured on the transfer. Later changes have no effect until the next packet.
  - O_ready drops the cycle after the transfer. O_busy rises the same cycle.
- Packet bytes:
  - Header = {I_port, 1'b0, I_size}, followed by 0/1/2/4 payload bytes.
  - Total bytes N = 1 + payload count.
- State machine: IDLE -> START -> DATA (8 bits, LSB first) -> STOP.
  - From STOP: go to START for the next byte, or to DONE after byte N.
  - DONE -> IDLE lasts 1 cycle: increments O_pkt_count and clears O_busy.
- Bit timing:
  - A divider counter reloads to the captured divisor at every half/bit boundary.
  - The first START level appears on O_swo the cycle after the transfer.
- NRZ mode:
  - Start = 0, data bits, stop = 1; each lasts div+1 cycles. Idle level 1.
  - Packet time = N*10*(div+1) cycles.
- Manchester mode:
  - Each bit = two half-periods of div+1 cycles.
  - '1' = high then low; '0' = low then high.
  - Start bit is a '1'. Stop is line low for one full bit time. Idle level 0.
  - Packet time = N*10*2*(div+1) cycles.
- Idle level: in IDLE, O_swo is registered to the idle level of the current I_manchester, one-cycle latency. After reset it is 1 until the first clock.
- O_ready timing: returns high the cycle after DONE, giving back-to-back packets a 2-cycle idle gap.
- I_enable deassertion:
  - Blocks new transfers.
  - A packet in flight always completes.
- Divisor 0 is legal: 1-cycle bit (NRZ) or 1-cycle half-bit (Manchester).
- O_pkt_count wraps from all-ones to 0 without any flag.
- I_size = 00 transmits only the header byte (N = 1).

Test Plan:
- NRZ, div=3, port=0, size=01, payload=0x41 -> O_swo frames 0x01 then 0x41, each bit 4 cycles. O_busy high 80 cycles, O_pkt_count = 1, O_ready high 2 cycles after the last stop bit ends.
- Manchester, div=1, port=3, size=10, payload=0xBEEF -> bytes 0x1A, 0xEF, 0xBE. Each bit 4 cycles with a mid-bit transition per encoding. Line low between bytes and at idle. Total 120 cycles.
- Size=11, payload=0x12345678 -> bytes 0x?B (header), 0x78, 0x56, 0x34, 0x12 in order. Changing I_payload during the send does not alter output.
- I_enable=0 with I_valid=1 -> O_ready stays 0, O_swo idle, count unchanged. Deasserting I_enable mid-packet -> packet completes, then O_ready stays 0.
- reset_n pulsed low during the 2nd data byte -> O_swo=1, O_busy=0, count=0 immediately. A new packet after release transmits correctly.
- 65536 header-only packets with div=0 -> O_pkt_count wraps to 0. Back-to-back transfers are accepted every N*10+2 cycles.
